// File: rtl/vector_packer.sv
// Purpose: packs per-chain beats of 1, M or N lanes into N-lane output vectors.
// Latency: one cycle from the accepting (or flushing) edge to valid_out.
// Backpressure: the output register stalls on !ready_in; ready_out drops while the output is held or a flush is pending.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   tracing                1 = packing beats, 0 = configuration byte stream
//   valid_in / ready_out   input beat handshake
//   eof_in, bof_in         frame flags ([0] inner loop, [1] outer loop), used by the condition byte and flush
//   chainId_in             selects the chain context (beat length, flush, condition)
//   configId, configData   configuration byte stream, accepted when configId matches PERSONAL_CONFIG_ID
//   vector_in              N input lanes, lane 0 first
//   vector_out, fill_out   packed vector (lane 0 oldest) and its count of valid lanes
//   valid_out / ready_in   output handshake
module vector_packer #(
  parameter int N = 8,
  parameter int M = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tracing,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [1:0]                    eof_in,
  input  logic [1:0]                    bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N*DATA_WIDTH-1:0]       vector_in,
  output logic [N*DATA_WIDTH-1:0]       vector_out,
  output logic [$clog2(N+1)-1:0]        fill_out,
  output logic                          valid_out,
  input  logic                          ready_in
);

  localparam int CHW = $clog2(MAX_CHAINS);
  localparam int FW  = $clog2(N+1);
  // count + L can reach 2N-1 before the overflow decision is taken.
  localparam int CW  = $clog2(2*N+1);
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int BCW = $clog2(2*MAX_CHAINS+1);

  localparam logic [CW-1:0]  N_C      = CW'(N);
  localparam logic [BCW-1:0] BC_MAX   = BCW'(2*MAX_CHAINS);
  localparam logic [BCW-1:0] CHAINS_C = BCW'(MAX_CHAINS);

  typedef logic [N-1:0][DATA_WIDTH-1:0] lanes_t;
  typedef enum logic {ACCUM, FLUSH_PEND} state_t;

  state_t         state, state_nxt;
  lanes_t         acc, acc_nxt;
  lanes_t         in_lanes, comb_vec, in_only, emit_src, emit_vec;
  logic [CW-1:0]  count, count_nxt, beat_len, sum;
  logic [FW-1:0]  emit_fill;
  logic           emit;

  logic [1:0]     fw_mode  [MAX_CHAINS];
  logic           fw_flush [MAX_CHAINS];
  logic [7:0]     fw_cond  [MAX_CHAINS];
  logic [BCW-1:0] byte_counter;

  logic [1:0]     mode;
  logic           flush_eof;
  logic           cond_valid;
  logic           out_free;
  logic           accept;

  // Condition byte: zero means always; otherwise OR of the enabled flag terms.
  function automatic logic cond_ok(input logic [7:0] c, input logic [1:0] eof, input logic [1:0] bof);
    logic [7:0] terms;
    terms = {~bof[1], bof[1], ~eof[1], eof[1], ~bof[0], bof[0], ~eof[0], eof[0]};
    return (c == 8'd0) || (|(c & terms));
  endfunction

  assign in_lanes   = vector_in;
  assign mode       = fw_mode[chainId_in];
  assign flush_eof  = fw_flush[chainId_in] && eof_in[0];
  assign cond_valid = cond_ok(fw_cond[chainId_in], eof_in, bof_in);

  assign out_free  = !valid_out || ready_in;
  assign ready_out = !reset && (state == ACCUM) && out_free;
  assign accept    = valid_in && ready_out && tracing && (mode != 2'd3) && cond_valid;

  always_comb begin
    case (mode)
      2'd0:    beat_len = N_C;
      2'd1:    beat_len = CW'(M);
      default: beat_len = CW'(1);
    endcase
  end

  assign sum = count + beat_len;

  // comb_vec: accumulator with the current beat appended; in_only: the beat alone at lane 0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      comb_vec[i] = '0;
      in_only[i]  = '0;
      if (i < int'(count))
        comb_vec[i] = acc[i];
      else if (i < int'(sum))
        comb_vec[i] = in_lanes[IW'(i - int'(count))];
      if (i < int'(beat_len))
        in_only[i] = in_lanes[i];
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    emit      = 1'b0;
    emit_src  = comb_vec;
    emit_fill = '0;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (sum > N_C) begin
            // Overflow: ship what is held and restart the accumulator with this beat.
            emit      = 1'b1;
            emit_src  = acc;
            emit_fill = count[FW-1:0];
            acc_nxt   = in_only;
            count_nxt = beat_len;
            if (flush_eof)
              state_nxt = FLUSH_PEND;
          end else if (sum == N_C || flush_eof) begin
            emit      = 1'b1;
            emit_src  = comb_vec;
            emit_fill = sum[FW-1:0];
            acc_nxt   = '0;
            count_nxt = '0;
          end else begin
            acc_nxt   = comb_vec;
            count_nxt = sum;
          end
        end
      end
      FLUSH_PEND: begin
        if (out_free) begin
          emit      = 1'b1;
          emit_src  = acc;
          emit_fill = count[FW-1:0];
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Lanes past the fill are forced to zero on the way out.
  always_comb begin
    for (int i = 0; i < N; i++)
      emit_vec[i] = (i < int'(emit_fill)) ? emit_src[i] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACCUM;
      acc        <= '0;
      count      <= '0;
      valid_out  <= 1'b0;
      vector_out <= '0;
      fill_out   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      if (emit) begin
        vector_out <= emit_vec;
        fill_out   <= emit_fill;
        valid_out  <= 1'b1;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

  // Configuration stream: condition bytes for every chain first, then firmware bytes.
  // MAX_CHAINS is a power of two, so the low counter bits index the chain in both halves.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_counter <= '0;
      for (int c = 0; c < MAX_CHAINS; c++) begin
        fw_mode[c]  <= INITIAL_FIRMWARE[8*c +: 2];
        fw_flush[c] <= INITIAL_FIRMWARE[8*c+7];
        fw_cond[c]  <= INITIAL_FIRMWARE_COND[8*c +: 8];
      end
    end else if (!tracing && configId == PERSONAL_CONFIG_ID) begin
      if (byte_counter < BC_MAX) begin
        if (byte_counter < CHAINS_C) begin
          fw_cond[byte_counter[CHW-1:0]] <= configData;
        end else begin
          fw_mode[byte_counter[CHW-1:0]]  <= configData[1:0];
          fw_flush[byte_counter[CHW-1:0]] <= configData[7];
        end
        byte_counter <= byte_counter + 1'b1;
      end
    end else begin
      byte_counter <= '0;
    end
  end

endmodule

// File: tb/tb_vector_packer.sv
// Directed bench for vector_packer with N=8, M=2, 32-bit lanes.
// Chain setup from reset: 0 = mode 1 + flush, 1 = mode 2, 2 = mode 0 + flush, 3 = disabled.
module tb_vector_packer;

  logic         clk;
  logic         reset;
  logic         tracing;
  logic         valid_in;
  logic         ready_out;
  logic [1:0]   eof_in;
  logic [1:0]   bof_in;
  logic [1:0]   chainId_in;
  logic [7:0]   configId;
  logic [7:0]   configData;
  logic [255:0] vector_in;
  logic [255:0] vector_out;
  logic [3:0]   fill_out;
  logic         valid_out;
  logic         ready_in;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [255:0] v;
    logic [3:0]   f;
  } out_t;
  out_t outq[$];

  localparam logic [31:0] JUNK = 32'hEEEE_EEEE;

  vector_packer #(
    .N(8), .M(2), .DATA_WIDTH(32), .MAX_CHAINS(4), .PERSONAL_CONFIG_ID(8'd0),
    .INITIAL_FIRMWARE(32'h0380_0281), .INITIAL_FIRMWARE_COND(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .tracing(tracing), .valid_in(valid_in), .ready_out(ready_out),
    .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chainId_in), .configId(configId),
    .configData(configData), .vector_in(vector_in), .vector_out(vector_out),
    .fill_out(fill_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every vector the downstream side consumes.
  always @(negedge clk) begin
    #2;
    if (!reset && valid_out && ready_in)
      outq.push_back({vector_out, fill_out});
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] seq8(input logic [31:0] base);
    logic [7:0][31:0] t;
    for (int k = 0; k < 8; k++) t[k] = base + 32'(k);
    return t;
  endfunction

  function automatic logic [255:0] one(input logic [31:0] a);
    return {{7{JUNK}}, a};
  endfunction

  function automatic logic [255:0] pair(input logic [31:0] a, input logic [31:0] b);
    return {{6{JUNK}}, b, a};
  endfunction

  // Presents one beat and returns just after the edge that accepts it.
  task automatic beat(input logic [1:0] ch, input logic [255:0] v, input logic [1:0] eof);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    chainId_in = ch;
    vector_in  = v;
    eof_in     = eof;
    valid_in   = 1'b1;
    #1;
    for (int w = 0; w < 50; w++) begin
      if (ready_out) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) check("beat_timeout", {255'd0, ready_out}, 256'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    eof_in   = 2'b00;
  endtask

  task automatic expect_out(input string tag, input logic [255:0] v, input logic [3:0] f);
    out_t o;
    int   w;
    w = 0;
    while (outq.size() == 0 && w < 40) begin
      @(negedge clk);
      #3;
      w++;
    end
    if (outq.size() == 0) begin
      check({tag, "_timeout"}, 256'(outq.size()), 256'd1);
    end else begin
      o = outq.pop_front();
      check({tag, "_vec"}, o.v, v);
      check({tag, "_fill"}, 256'(o.f), 256'(f));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cfg [10];
    cfg = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h81, 8'h02, 8'h02, 8'h00, 8'hFF, 8'hFF};

    reset = 1'b1; tracing = 1'b1; valid_in = 1'b0; eof_in = 2'b00; bof_in = 2'b00;
    chainId_in = 2'd0; configId = 8'hFF; configData = 8'h00; vector_in = '0; ready_in = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {255'd0, ready_out}, 256'd0);
    check("rst_valid", {255'd0, valid_out}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_fill", 256'(fill_out), 256'd0);
    check("rst_vec", vector_out, 256'd0);
    check("rst_ready_after", {255'd0, ready_out}, 256'd1);

    // Mode 2: eight single-lane beats fill one vector
    for (int i = 0; i < 8; i++) begin
      beat(2'd1, one(32'(1 + i)), 2'b00);
      if (i == 6) begin
        #1;
        check("m2_no_early", {255'd0, valid_out}, 256'd0);
      end
    end
    #1;
    check("m2_latency", {255'd0, valid_out}, 256'd1);
    check("m2_fill_now", 256'(fill_out), 256'd8);
    idle();
    expect_out("m2", seq8(32'd1), 4'd8);

    // Mode 1 with flush on eof
    beat(2'd0, pair(32'h11, 32'h12), 2'b00);
    beat(2'd0, pair(32'h13, 32'h14), 2'b00);
    beat(2'd0, pair(32'h15, 32'h16), 2'b01);
    idle();
    expect_out("m1_flush", {64'd0, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11}, 4'd6);

    // Mode 1 without eof: four pairs fill exactly
    for (int i = 0; i < 4; i++)
      beat(2'd0, pair(32'(32'h21 + 2*i), 32'(32'h22 + 2*i)), 2'b00);
    idle();
    expect_out("m1_full", seq8(32'h21), 4'd8);

    // Overflow with flush: count 6 then an 8-lane beat with eof
    for (int i = 0; i < 3; i++)
      beat(2'd0, pair(32'(32'h31 + 2*i), 32'(32'h32 + 2*i)), 2'b00);
    beat(2'd2, seq8(32'hA0), 2'b01);
    #1;
    check("ovf_first_fill", 256'(fill_out), 256'd6);
    check("ovf_pend_ready", {255'd0, ready_out}, 256'd0);
    idle();
    @(posedge clk);
    #1;
    check("ovf_second_fill", 256'(fill_out), 256'd8);
    check("ovf_ready_back", {255'd0, ready_out}, 256'd1);
    expect_out("ovf_a", {64'd0, 32'h36, 32'h35, 32'h34, 32'h33, 32'h32, 32'h31}, 4'd6);
    expect_out("ovf_b", seq8(32'hA0), 4'd8);

    // Backpressure: output held for five cycles, pending beat not taken
    @(negedge clk);
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++)
      beat(2'd1, one(32'(32'h30 + i)), 2'b00);
    @(negedge clk);
    chainId_in = 2'd1; vector_in = one(32'h40); eof_in = 2'b00; valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", {255'd0, ready_out}, 256'd0);
      check("bp_valid", {255'd0, valid_out}, 256'd1);
      check("bp_stable", vector_out, seq8(32'h30));
      @(negedge clk);
    end
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("bp_consumed", {255'd0, valid_out}, 256'd0);
    for (int i = 1; i < 8; i++)
      beat(2'd1, one(32'(32'h40 + i)), 2'b00);
    idle();
    expect_out("bp_held", seq8(32'h30), 4'd8);
    expect_out("bp_next", seq8(32'h40), 4'd8);

    // Reset mid-accumulation discards the partial vector
    for (int i = 0; i < 3; i++)
      beat(2'd1, one(32'(32'h50 + i)), 2'b00);
    idle();
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {255'd0, ready_out}, 256'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {255'd0, valid_out}, 256'd0);
    check("mid_rst_noout", 256'(outq.size()), 256'd0);
    for (int i = 0; i < 8; i++)
      beat(2'd1, one(32'(9 + i)), 2'b00);
    idle();
    expect_out("post_rst", seq8(32'd9), 4'd8);

    // Disabled chain drops its beat
    beat(2'd3, one(32'hDD), 2'b00);
    for (int i = 0; i < 8; i++)
      beat(2'd1, one(32'(32'h60 + i)), 2'b00);
    idle();
    expect_out("disabled_drop", seq8(32'h60), 4'd8);

    // Configuration stream, with a beat offered while tracing is low
    @(negedge clk);
    tracing = 1'b0; configId = 8'd0;
    chainId_in = 2'd1; vector_in = one(32'hBAD); valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      configData = cfg[k];
      @(negedge clk);
      if (k == 7) check("cfg_count8", 256'(dut.byte_counter), 256'd8);
    end
    check("cfg_saturate", 256'(dut.byte_counter), 256'd8);
    configId = 8'hFF; valid_in = 1'b0;
    @(negedge clk);
    check("cfg_clear", 256'(dut.byte_counter), 256'd0);
    tracing = 1'b1;

    // chain0: mode 1 + flush
    beat(2'd0, pair(32'h51, 32'h52), 2'b00);
    beat(2'd0, pair(32'h53, 32'h54), 2'b01);
    idle();
    expect_out("cfg_ch0", {128'd0, 32'h54, 32'h53, 32'h52, 32'h51}, 4'd4);

    // chain2: mode 2, accepted only with eof_in[0]=1
    beat(2'd2, one(32'h99), 2'b00);
    for (int i = 0; i < 8; i++)
      beat(2'd2, one(32'(32'h61 + i)), 2'b01);
    idle();
    expect_out("cfg_ch2_cond", seq8(32'h61), 4'd8);

    // chain3: now mode 0
    beat(2'd3, seq8(32'h71), 2'b00);
    idle();
    expect_out("cfg_ch3", seq8(32'h71), 4'd8);

    repeat (3) @(negedge clk);
    check("no_extra_out", 256'(outq.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
